// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA stream receiver writing a row-major frame window to RAM (FRAME_DECIM_EN: 2:1 decimation)
module vga_frame_capture #(
   parameter int H_START = 144,
   parameter int V_START = 35,
   parameter int X_OFF   = 0,
   parameter int Y_OFF   = 0,
   parameter int IMG_W   = 160,
   parameter int IMG_H   = 120,
   parameter int ADDR_W  = 19
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pix_en,
   input  logic              hsync_n,
   input  logic              vsync_n,
   input  logic [7:0]        pixel_in,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic              wren,
   output logic [ADDR_W-1:0] waddr,
   output logic [7:0]        wdata,
   output logic [7:0]        frame_count
);

   localparam int CNT_W = 12;
`ifdef FRAME_DECIM_EN
   localparam int SPAN_W = 2 * IMG_W;
   localparam int SPAN_H = 2 * IMG_H;
`else
   localparam int SPAN_W = IMG_W;
   localparam int SPAN_H = IMG_H;
`endif
   localparam logic [CNT_W-1:0]  X_LO      = CNT_W'(H_START + X_OFF);
   localparam logic [CNT_W-1:0]  X_HI      = CNT_W'(H_START + X_OFF + SPAN_W);
   localparam logic [CNT_W-1:0]  Y_LO      = CNT_W'(V_START + Y_OFF);
   localparam logic [CNT_W-1:0]  Y_HI      = CNT_W'(V_START + Y_OFF + SPAN_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

   state_t            r_state;
   logic              r_prev_hs;
   logic              r_prev_vs;
   logic [CNT_W-1:0]  r_h_cnt;
   logic [CNT_W-1:0]  r_v_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_done;
   logic              r_frame_err;
   logic              r_wren;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wdata;
   logic [7:0]        r_frame_count;

   logic              w_hs_fall;
   logic              w_vs_fall;
   logic [CNT_W-1:0]  w_h_nxt;
   logic [CNT_W-1:0]  w_v_nxt;
   logic              w_in_rect;
   logic              w_in_win;

   // Sync edges only exist on pixel strobes; the sampled pixel carries the updated counter values,
   // so the pixel on which hsync falls is h=0 and the line on which vsync falls is v=0.
   assign w_hs_fall = pix_en & r_prev_hs & ~hsync_n;
   assign w_vs_fall = pix_en & r_prev_vs & ~vsync_n;
   assign w_h_nxt   = w_hs_fall ? '0 : ((&r_h_cnt) ? r_h_cnt : r_h_cnt + 1'b1);
   assign w_v_nxt   = w_vs_fall ? '0 : (w_hs_fall ? r_v_cnt + 1'b1 : r_v_cnt);
   assign w_in_rect = pix_en && (w_h_nxt >= X_LO) && (w_h_nxt < X_HI)
                             && (w_v_nxt >= Y_LO) && (w_v_nxt < Y_HI);
`ifdef FRAME_DECIM_EN
   assign w_in_win  = w_in_rect & ~(w_h_nxt[0] ^ X_LO[0]) & ~(w_v_nxt[0] ^ Y_LO[0]);
`else
   assign w_in_win  = w_in_rect;
`endif

   assign busy        = (r_state == S_ARM) || (r_state == S_CAPTURE);
   assign done        = r_done;
   assign frame_err   = r_frame_err;
   assign wren        = r_wren;
   assign waddr       = r_waddr;
   assign wdata       = r_wdata;
   assign frame_count = r_frame_count;

   // Raster position tracking, frozen while pix_en is low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev_hs <= 1'b1;
         r_prev_vs <= 1'b1;
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
      end else if (pix_en) begin
         r_prev_hs <= hsync_n;
         r_prev_vs <= vsync_n;
         r_h_cnt   <= w_h_nxt;
         r_v_cnt   <= w_v_nxt;
      end
   end

   // Capture FSM with registered write port and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_done        <= 1'b0;
         r_frame_err   <= 1'b0;
         r_wren        <= 1'b0;
         r_waddr       <= '0;
         r_wdata       <= '0;
         r_frame_count <= '0;
      end else begin
         r_wren <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_ARM;
                  r_frame_err <= 1'b0;
                  r_addr      <= '0;
               end
            end
            S_ARM: begin
               if (w_vs_fall) r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (w_vs_fall) begin
                  // frame ended early: abandon without done
                  r_frame_err <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (w_in_win) begin
                  r_wren  <= 1'b1;
                  r_wdata <= pixel_in;
                  r_waddr <= r_addr;
                  r_addr  <= r_addr + 1'b1;
                  if (r_addr == LAST_ADDR) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done        <= 1'b1;
               r_frame_count <= r_frame_count + 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb/tb_vga_frame_capture.sv - directed self-checking bench for vga_frame_capture
module tb_vga_frame_capture;

   localparam int AW = 19;
`ifdef FRAME_DECIM_EN
   localparam int LINE_LEN   = 14;
   localparam int N_LINES    = 7;
   localparam int TRUNC_LINE = 4;
   localparam int TRUNC_NPIX = 5;
   localparam int RST_NPIX   = 9;
`else
   localparam int LINE_LEN   = 10;
   localparam int N_LINES    = 5;
   localparam int TRUNC_LINE = 3;
   localparam int TRUNC_NPIX = 5;
   localparam int RST_NPIX   = 7;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pix_en = 1'b0;
   logic          hsync_n = 1'b1;
   logic          vsync_n = 1'b1;
   logic [7:0]    pixel_in = 8'h00;
   logic          start = 1'b0;
   logic          busy, done, frame_err, wren;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata, frame_count;

   int total = 0;
   int bad = 0;

   logic [AW-1:0] q_addr[$];
   logic [7:0]    q_data[$];
   bit            q_ok[$];
   int            cyc = 0;
   int            done_cnt = 0;
   int            done_cyc = -1;
   int            last_wr_cyc = -100;
   logic          prev_pe = 1'b0;
   logic [7:0]    prev_pix = 8'h00;
   int            g_sl = -1;
   int            g_sp = -1;

   vga_frame_capture #(
      .H_START(4), .V_START(2), .X_OFF(0), .Y_OFF(0),
      .IMG_W(4), .IMG_H(2), .ADDR_W(AW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .hsync_n(hsync_n),
      .vsync_n(vsync_n), .pixel_in(pixel_in), .start(start), .busy(busy),
      .done(done), .frame_err(frame_err), .wren(wren), .waddr(waddr),
      .wdata(wdata), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Write/done recorder, sampled on the falling edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (wren) begin
         q_addr.push_back(waddr);
         q_data.push_back(wdata);
         q_ok.push_back(prev_pe && (wdata == prev_pix));
         if (waddr == AW'(7)) last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      prev_pe  = pix_en;
      prev_pix = pixel_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int i);
`ifdef FRAME_DECIM_EN
      return 32'((4 + 2 * (i % 4)) + 16 * (2 + 2 * (i / 4)));
`else
      return 32'((4 + (i % 4)) + 16 * (2 + (i / 4)));
`endif
   endfunction

   task automatic send_line(input int l, input bit vs_lo, input int npix, input int gap);
      for (int p = 0; p < npix; p++) begin
         @(posedge clk); #1;
         hsync_n  = (p < 2) ? 1'b0 : 1'b1;
         vsync_n  = vs_lo ? 1'b0 : 1'b1;
         pixel_in = 8'(p + 16 * l);
         pix_en   = 1'b1;
         start    = (l == g_sl && p == g_sp) ? 1'b1 : 1'b0;
         for (int g = 1; g < gap; g++) begin
            @(posedge clk); #1;
            pix_en = 1'b0;
            start  = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input int gap);
      for (int l = 0; l < N_LINES; l++) send_line(l, l == 0, LINE_LEN, gap);
      @(posedge clk); #1;
      pix_en = 1'b0;
      start  = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      pix_en = 1'b0;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      q_ok.delete();
      done_cnt    = 0;
      done_cyc    = -1;
      last_wr_cyc = -100;
   endtask

   task automatic check_full(input string tag, input bit check_ok);
      chk({tag, "_nwr"}, 32'(q_addr.size()), 32'd8);
      for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
         chk({tag, "_addr"}, 32'(q_addr[i]), 32'(i));
         chk({tag, "_data"}, 32'(q_data[i]), exp_data(i));
         if (check_ok) chk({tag, "_lat"}, 32'(q_ok[i]), 32'd1);
      end
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      chk("rst_wren", 32'(wren), 32'd0);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_fcnt", 32'(frame_count), 32'd0);
      reset_n = 1'b1;

      // 1: one start, two frames -> one window captured
      clear_log();
      pulse_start();
      chk("t1_busy_arm", 32'(busy), 32'd1);
      send_frame(1);
      send_frame(1);
      check_full("t1", 1'b1);
      chk("t1_fcnt", 32'(frame_count), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_err", 32'(frame_err), 32'd0);

      // 2: vsync falls after 5 writes
      clear_log();
      pulse_start();
      for (int l = 0; l < TRUNC_LINE; l++) send_line(l, l == 0, LINE_LEN, 1);
      send_line(TRUNC_LINE, 1'b0, TRUNC_NPIX, 1);
      send_line(0, 1'b1, LINE_LEN, 1);
      send_line(1, 1'b0, LINE_LEN, 1);
      chk("t2_nwr", 32'(q_addr.size()), 32'd5);
      chk("t2_err", 32'(frame_err), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_done", 32'(done_cnt), 32'd0);
      chk("t2_fcnt", 32'(frame_count), 32'd1);
      pulse_start();
      chk("t2_err_clr", 32'(frame_err), 32'd0);
      chk("t2_busy_arm", 32'(busy), 32'd1);

      // 3: start pulsed mid-capture is ignored
      clear_log();
      g_sl = 2;
      g_sp = 6;
      send_frame(1);
      g_sl = -1;
      g_sp = -1;
      check_full("t3", 1'b1);
      chk("t3_fcnt", 32'(frame_count), 32'd2);

      // 4: pix_en every second clock
      clear_log();
      pulse_start();
      send_frame(2);
      check_full("t4", 1'b1);
      chk("t4_fcnt", 32'(frame_count), 32'd3);

      // 5: reset at the third write
      clear_log();
      pulse_start();
      send_line(0, 1'b1, LINE_LEN, 1);
      send_line(1, 1'b0, LINE_LEN, 1);
      send_line(2, 1'b0, RST_NPIX, 1);
      @(posedge clk); #1;
      pix_en = 1'b0;
      chk("t5_wren3", 32'(wren), 32'd1);
      chk("t5_waddr3", 32'(waddr), 32'd2);
      reset_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_wren", 32'(wren), 32'd0);
      chk("t5_waddr", 32'(waddr), 32'd0);
      chk("t5_wdata", 32'(wdata), 32'd0);
      chk("t5_fcnt", 32'(frame_count), 32'd0);
      chk("t5_err", 32'(frame_err), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      clear_log();
      send_frame(1);
      send_frame(1);
      chk("t5_no_wr", 32'(q_addr.size()), 32'd0);
      chk("t5_no_done", 32'(done_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
